// File: rtl/game_session_if.sv
// Key/timer handshake bundle between the typing-game session sequencer and its neighbours.
// The sequencer uses the slave modport; the key decoder/timer side uses master.
interface game_session_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic       end_game;
  logic       menu_or_game;
  logic       start;
  logic [1:0] mode;
  logic [2:0] phase;
  logic [3:0] ready_left;
  logic       abort;

  modport master (
    output key_valid, key_code, end_game,
    input  menu_or_game, start, mode, phase, ready_left, abort
  );

  modport slave (
    input  key_valid, key_code, end_game,
    output menu_or_game, start, mode, phase, ready_left, abort
  );
endinterface

// File: rtl/game_session_ctrl.sv
// Session sequencer: MENU -> READY -> PLAY (-> PAUSE) -> OVER -> MENU, driving the countdown timer.
// Optional pause support is built when GSC_PAUSE_EN is defined.
module game_session_ctrl #(
  parameter int CLK_HZ      = 25000000,
  parameter int READY_SECS  = 3,
  parameter int RESULT_SECS = 5
) (
  input  logic         clk,
  input  logic         rst,
  game_session_if.slave bus
);
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [7:0] K_1     = 8'h31;
  localparam logic [7:0] K_2     = 8'h32;
  localparam logic [7:0] K_3     = 8'h33;
  localparam logic [7:0] K_ENTER = 8'h0D;
  localparam logic [7:0] K_ESC   = 8'h1B;
`ifdef GSC_PAUSE_EN
  localparam logic [7:0] K_TAB   = 8'h09;
`endif

  typedef enum logic [2:0] {
    MENU  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } phase_e;

  phase_e        phase_q, phase_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [3:0]    ready_q, ready_nxt;
  logic [3:0]    res_q, res_nxt;
  logic [1:0]    mode_q, mode_nxt;
  logic          abort_q, abort_nxt;
  logic          mog_q, mog_nxt;
  logic          start_q, start_nxt;
  logic          tick, k_enter, k_esc;

  assign tick    = (cnt_q == CW'(CLK_HZ - 1));
  assign k_enter = bus.key_valid && (bus.key_code == K_ENTER);
  assign k_esc   = bus.key_valid && (bus.key_code == K_ESC);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= MENU;
      cnt_q   <= '0;
      ready_q <= '0;
      res_q   <= '0;
      mode_q  <= 2'b00;
      abort_q <= 1'b0;
      mog_q   <= 1'b1;
      start_q <= 1'b0;
    end else begin
      phase_q <= phase_nxt;
      cnt_q   <= cnt_nxt;
      ready_q <= ready_nxt;
      res_q   <= res_nxt;
      mode_q  <= mode_nxt;
      abort_q <= abort_nxt;
      mog_q   <= mog_nxt;
      start_q <= start_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase_q;
    ready_nxt = ready_q;
    res_nxt   = res_q;
    mode_nxt  = mode_q;
    abort_nxt = abort_q;
    case (phase_q)
      MENU: begin
        if (bus.key_valid) begin
          case (bus.key_code)
            K_1:     mode_nxt = 2'b00;
            K_2:     mode_nxt = 2'b01;
            K_3:     mode_nxt = 2'b10;
            K_ENTER: begin
              phase_nxt = READY;
              ready_nxt = 4'(READY_SECS);
              abort_nxt = 1'b0;
            end
            default: ;
          endcase
        end
      end
      READY: begin
        // ESC beats a coincident tick so an abort never lands in PLAY
        if (k_esc) begin
          phase_nxt = MENU;
          ready_nxt = '0;
        end else if (tick) begin
          if (ready_q <= 4'd1) begin
            phase_nxt = PLAY;
            ready_nxt = '0;
          end else begin
            ready_nxt = ready_q - 4'd1;
          end
        end
      end
      PLAY: begin
        if (bus.end_game) begin
          phase_nxt = OVER;
          abort_nxt = 1'b0;
        end else if (k_esc) begin
          phase_nxt = OVER;
          abort_nxt = 1'b1;
        end
`ifdef GSC_PAUSE_EN
        else if (bus.key_valid && bus.key_code == K_TAB) begin
          phase_nxt = PAUSE;
        end
`endif
      end
`ifdef GSC_PAUSE_EN
      PAUSE: begin
        if (bus.end_game) begin
          phase_nxt = OVER;
          abort_nxt = 1'b0;
        end else if (k_esc) begin
          phase_nxt = OVER;
          abort_nxt = 1'b1;
        end else if (bus.key_valid && bus.key_code == K_TAB) begin
          phase_nxt = PLAY;
        end
      end
`endif
      OVER: begin
        if (k_enter || (tick && res_q == 4'(RESULT_SECS - 1))) begin
          phase_nxt = MENU;
        end else if (tick) begin
          res_nxt = res_q + 4'd1;
        end
      end
      default: begin
        phase_nxt = MENU;
        ready_nxt = '0;
      end
    endcase

    // every phase starts on a fresh full second
    if (phase_nxt != phase_q) begin
      cnt_nxt = '0;
      res_nxt = '0;
    end else if (tick) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt_q + 1'b1;
    end

    mog_nxt   = (phase_nxt == MENU);
    start_nxt = (phase_nxt == PLAY);
  end

  assign bus.phase        = phase_q;
  assign bus.menu_or_game = mog_q;
  assign bus.start        = start_q;
  assign bus.mode         = mode_q;
  assign bus.ready_left   = ready_q;
  assign bus.abort        = abort_q;
endmodule
